// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one handshake-style memory port between the I-cache
// (read-only) and the D-cache (read/write) refill and write-back paths.
// One requester is served at a time. Ties are broken round-robin. Every
// memory-side output comes straight from a register. Each port gets its own
// held read data and a one-cycle completion pulse.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e            state_q;
    logic              lastGntD_q;
    logic              gntD_q;
    logic              memRead_q;
    logic              memWrite_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memWdata_q;
    logic [DATA_W-1:0] iRdata_q;
    logic [DATA_W-1:0] dRdata_q;
    logic              iReady_q;
    logic              dReady_q;

    logic              iValid;
    logic              dValid;
    logic              grantD_d;

    // Qualify the requests and pick the winner. On a tie, the port that did not win last time is chosen.
    always_comb begin
        iValid   = i_read;
        dValid   = d_read ^ d_write;
        grantD_d = dValid && (!iValid || !lastGntD_q);
    end

    // Arbitration FSM. It owns every registered output and tracks the round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lastGntD_q <= 1'b0;
            gntD_q     <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            iRdata_q   <= '0;
            dRdata_q   <= '0;
            iReady_q   <= 1'b0;
            dReady_q   <= 1'b0;
        end else begin
            iReady_q <= 1'b0;
            dReady_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iValid || dValid) begin
                        gntD_q  <= grantD_d;
                        state_q <= ACCESS;
                        if (grantD_d) begin
                            memAddr_q  <= d_addr;
                            memRead_q  <= d_read;
                            memWrite_q <= d_write;
                            memWdata_q <= d_write ? d_wdata : '0;
                        end else begin
                            memAddr_q  <= i_addr;
                            memRead_q  <= 1'b1;
                            memWrite_q <= 1'b0;
                            memWdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (gntD_q) begin
                            dReady_q <= 1'b1;
                            if (memRead_q) begin
                                dRdata_q <= mem_rdata;
                            end
                        end else begin
                            iReady_q <= 1'b1;
                            iRdata_q <= mem_rdata;
                        end
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                        lastGntD_q <= gntD_q;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!mem_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = iRdata_q;
    assign i_ready   = iReady_q;
    assign d_rdata   = dRdata_q;
    assign d_ready   = dReady_q;
    assign mem_read  = memRead_q;
    assign mem_write = memWrite_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule
